// File: rtl/sdram_wb_arbiter.sv
// Shares one pipelined Wishbone slave port (SDRAM controller) between NM masters.
// Define SDRAM_ARB_FIXED_PRIO_EN for fixed priority with strobe-boundary preemption; default is round-robin.
module sdram_wb_arbiter #(
    parameter int NM     = 2,
    parameter int AWIDTH = 26,
    parameter int MAXOUT = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NM-1:0]        m_cyc_i,
    input  logic [NM-1:0]        m_stb_i,
    input  logic [NM-1:0]        m_we_i,
    input  logic [4*NM-1:0]      m_sel_i,
    input  logic [AWIDTH*NM-1:0] m_adr_i,
    input  logic [32*NM-1:0]     m_dat_i,
    output logic [NM-1:0]        m_stall_o,
    output logic [NM-1:0]        m_ack_o,
    output logic [31:0]          m_dat_o,
    output logic                 s_cyc_o,
    output logic                 s_stb_o,
    output logic                 s_we_o,
    output logic [3:0]           s_sel_o,
    output logic [AWIDTH-1:0]    s_adr_o,
    output logic [31:0]          s_dat_o,
    input  logic                 s_stall_i,
    input  logic                 s_ack_i,
    input  logic [31:0]          s_dat_i
);

    localparam int GW = (NM > 1) ? $clog2(NM) : 1;
    localparam int OW = $clog2(MAXOUT) + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OWN,
        ST_DRAIN
    } state_t;

    state_t          state;
    logic [GW-1:0]   grant;
    logic [OW-1:0]   outstanding;
    logic [OW-1:0]   out_nx;
    logic            full;
    logic            accept;
    logic            ack_ok;

    logic            g_cyc;
    logic            g_stb;
    logic            g_we;
    logic [3:0]      g_sel;
    logic [AWIDTH-1:0] g_adr;
    logic [31:0]     g_dat;

    logic            hit;
    logic [GW-1:0]   hit_idx;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    logic            lower_req;
`else
    logic [GW-1:0]   rr_ptr;
    logic [GW-1:0]   hit_rr;
`endif

    assign full   = (outstanding == OW'(MAXOUT));
    assign accept = s_stb_o & ~s_stall_i;
    // Acks with nothing outstanding (e.g. stragglers after a reset) are dropped here.
    assign ack_ok = s_ack_i & (outstanding != '0);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        g_cyc = 1'b0;
        g_stb = 1'b0;
        g_we  = 1'b0;
        g_sel = '0;
        g_adr = '0;
        g_dat = '0;
        for (int k = 0; k < NM; k++) begin
            if (GW'(k) == grant) begin
                g_cyc = m_cyc_i[k];
                g_stb = m_stb_i[k];
                g_we  = m_we_i[k];
                g_sel = m_sel_i[4*k +: 4];
                g_adr = m_adr_i[AWIDTH*k +: AWIDTH];
                g_dat = m_dat_i[32*k +: 32];
            end
        end
    end

    always_comb begin
        out_nx = outstanding;
        if (accept && !ack_ok)
            out_nx = outstanding + OW'(1);
        else if (!accept && ack_ok)
            out_nx = outstanding - OW'(1);
    end

`ifdef SDRAM_ARB_FIXED_PRIO_EN
    always_comb begin
        hit       = 1'b0;
        hit_idx   = '0;
        lower_req = 1'b0;
        for (int k = NM - 1; k >= 0; k--) begin
            if (m_cyc_i[k]) begin
                hit     = 1'b1;
                hit_idx = GW'(k);
            end
        end
        for (int k = 0; k < NM; k++) begin
            if (m_cyc_i[k] && (GW'(k) < grant))
                lower_req = 1'b1;
        end
    end
`else
    always_comb begin
        int idx;
        hit     = 1'b0;
        hit_idx = '0;
        hit_rr  = '0;
        idx     = 0;
        for (int i = 0; i < NM; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NM)
                idx = idx - NM;
            for (int k = 0; k < NM; k++) begin
                if (!hit && (k == idx) && m_cyc_i[k]) begin
                    hit     = 1'b1;
                    hit_idx = GW'(k);
                    hit_rr  = GW'((k + 1) % NM);
                end
            end
        end
    end
`endif

    always_comb begin
        m_stall_o = '1;
        m_ack_o   = '0;
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_sel_o   = '0;
        s_adr_o   = '0;
        s_dat_o   = '0;
        case (state)
            ST_OWN: begin
                s_cyc_o = 1'b1;
                s_stb_o = g_stb & ~full;
                s_we_o  = g_we;
                s_sel_o = g_sel;
                s_adr_o = g_adr;
                s_dat_o = g_dat;
                for (int k = 0; k < NM; k++) begin
                    if (GW'(k) == grant) begin
                        m_stall_o[k] = s_stall_i | full;
                        m_ack_o[k]   = ack_ok;
                    end
                end
            end
            ST_DRAIN: s_cyc_o = 1'b1;
            default: ;
        endcase
    end

    assign m_dat_o = (state != ST_IDLE) ? s_dat_i : 32'h0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            grant       <= '0;
            outstanding <= '0;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
            rr_ptr      <= '0;
`endif
        end else begin
            outstanding <= out_nx;
            case (state)
                ST_IDLE: begin
                    if (hit) begin
                        grant <= hit_idx;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
                        rr_ptr <= hit_rr;
`endif
                        state <= ST_OWN;
                    end
                end
                ST_OWN: begin
                    if (!g_cyc)
                        state <= (out_nx == '0) ? ST_IDLE : ST_DRAIN;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
                    else if (lower_req && !g_stb)
                        state <= ST_DRAIN;
`endif
                end
                ST_DRAIN: begin
                    if (out_nx == '0)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_wb_arbiter.sv
// Directed bench for sdram_wb_arbiter (NM=2, AWIDTH=26, MAXOUT=4): vector table plus hand-written corner sequences.
module tb_sdram_wb_arbiter;

    localparam int NM = 2;
    localparam int AW = 26;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [NM-1:0]   m_cyc_i, m_stb_i, m_we_i;
    logic [4*NM-1:0] m_sel_i;
    logic [AW*NM-1:0] m_adr_i;
    logic [32*NM-1:0] m_dat_i;
    logic [NM-1:0]   m_stall_o, m_ack_o;
    logic [31:0]     m_dat_o;
    logic            s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]      s_sel_o;
    logic [AW-1:0]   s_adr_o;
    logic [31:0]     s_dat_o;
    logic            s_stall_i, s_ack_i;
    logic [31:0]     s_dat_i;

    int errors = 0;
    int checks = 0;

    sdram_wb_arbiter #(.NM(NM), .AWIDTH(AW), .MAXOUT(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_sel_i(m_sel_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i),
        .m_stall_o(m_stall_o), .m_ack_o(m_ack_o), .m_dat_o(m_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
        .s_stall_i(s_stall_i), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          rst;
        logic [1:0]    cyc;
        logic [1:0]    stb;
        logic          stall;
        logic          ack;
        logic [AW-1:0] adr0;
        logic          exp_scyc;
        logic          exp_sstb;
        logic [1:0]    exp_mstall;
        logic [1:0]    exp_mack;
        logic [AW-1:0] exp_adr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic [1:0] cyc, input logic [1:0] stb,
                                input logic stall, input logic ack, input logic [AW-1:0] adr0,
                                input logic scyc, input logic sstb, input logic [1:0] mstall,
                                input logic [1:0] mack, input logic [AW-1:0] adr);
        vec_t v;
        v.rst = rst; v.cyc = cyc; v.stb = stb; v.stall = stall; v.ack = ack; v.adr0 = adr0;
        v.exp_scyc = scyc; v.exp_sstb = sstb; v.exp_mstall = mstall; v.exp_mack = mack;
        v.exp_adr = adr;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Each cycle starts 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        m_cyc_i = '0; m_stb_i = '0; m_we_i = '0; m_sel_i = '0;
        m_dat_i = '0; s_stall_i = 1'b0; s_ack_i = 1'b0; s_dat_i = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1'b1;
        #1;
        rst_i = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int i);
        if (v.rst) do_reset();
        m_cyc_i = v.cyc; m_stb_i = v.stb; s_stall_i = v.stall; s_ack_i = v.ack;
        m_adr_i[AW-1:0] = v.adr0;
        #2;
        check($sformatf("v%0d_s_cyc", i),   64'(s_cyc_o),   64'(v.exp_scyc));
        check($sformatf("v%0d_s_stb", i),   64'(s_stb_o),   64'(v.exp_sstb));
        check($sformatf("v%0d_m_stall", i), 64'(m_stall_o), 64'(v.exp_mstall));
        check($sformatf("v%0d_m_ack", i),   64'(m_ack_o),   64'(v.exp_mack));
        check($sformatf("v%0d_s_adr", i),   64'(s_adr_o),   64'(v.exp_adr));
        tick();
    endtask

    initial begin
        idle_inputs();
        m_adr_i = '0;
        m_adr_i[2*AW-1:AW] = 26'h200;
        rst_i = 1'b1;
        #2;
        check("rst_s_cyc",   64'(s_cyc_o),   64'h0);
        check("rst_m_stall", 64'(m_stall_o), 64'h3);
        check("rst_s_adr",   64'(s_adr_o),   64'h0);
        check("rst_s_sel",   64'(s_sel_o),   64'h0);
        check("rst_out",     64'(dut.outstanding), 64'h0);
        tick();
        rst_i = 1'b0;

        for (int i = 0; i < 10; i++) begin
            #2;
            check($sformatf("idle%0d_s_cyc", i),   64'(s_cyc_o),   64'h0);
            check($sformatf("idle%0d_m_stall", i), 64'(m_stall_o), 64'h3);
            check($sformatf("idle%0d_out", i),     64'(dut.outstanding), 64'h0);
            tick();
        end

        // M0: four back-to-back reads, slave acks two cycles after each accept.
        vecs.push_back(mk(0, 2'b01, 2'b01, 0, 0, 26'h100, 0, 0, 2'b11, 2'b00, 26'h000));
        vecs.push_back(mk(0, 2'b01, 2'b01, 0, 0, 26'h100, 1, 1, 2'b10, 2'b00, 26'h100));
        vecs.push_back(mk(0, 2'b01, 2'b01, 0, 0, 26'h104, 1, 1, 2'b10, 2'b00, 26'h104));
        vecs.push_back(mk(0, 2'b01, 2'b01, 0, 1, 26'h108, 1, 1, 2'b10, 2'b01, 26'h108));
        vecs.push_back(mk(0, 2'b01, 2'b01, 0, 1, 26'h10C, 1, 1, 2'b10, 2'b01, 26'h10C));
        vecs.push_back(mk(0, 2'b01, 2'b00, 0, 1, 26'h10C, 1, 0, 2'b10, 2'b01, 26'h10C));
        vecs.push_back(mk(0, 2'b01, 2'b00, 0, 1, 26'h10C, 1, 0, 2'b10, 2'b01, 26'h10C));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0, 0, 26'h000, 1, 0, 2'b10, 2'b00, 26'h000));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0, 0, 26'h000, 0, 0, 2'b11, 2'b00, 26'h000));
`ifndef SDRAM_ARB_FIXED_PRIO_EN
        // Round-robin from reset: M0, M1, M0, M1 with an idle cycle between owners.
        vecs.push_back(mk(1, 2'b11, 2'b00, 0, 0, 26'h100, 0, 0, 2'b11, 2'b00, 26'h000));
        vecs.push_back(mk(0, 2'b11, 2'b00, 0, 0, 26'h100, 1, 0, 2'b10, 2'b00, 26'h100));
        vecs.push_back(mk(0, 2'b10, 2'b00, 0, 0, 26'h100, 1, 0, 2'b10, 2'b00, 26'h100));
        vecs.push_back(mk(0, 2'b10, 2'b00, 0, 0, 26'h100, 0, 0, 2'b11, 2'b00, 26'h000));
        vecs.push_back(mk(0, 2'b10, 2'b10, 0, 0, 26'h100, 1, 1, 2'b01, 2'b00, 26'h200));
        vecs.push_back(mk(0, 2'b10, 2'b00, 0, 1, 26'h100, 1, 0, 2'b01, 2'b10, 26'h200));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0, 0, 26'h100, 1, 0, 2'b01, 2'b00, 26'h200));
        vecs.push_back(mk(0, 2'b11, 2'b00, 0, 0, 26'h100, 0, 0, 2'b11, 2'b00, 26'h000));
        vecs.push_back(mk(0, 2'b11, 2'b00, 0, 0, 26'h100, 1, 0, 2'b10, 2'b00, 26'h100));
        vecs.push_back(mk(0, 2'b10, 2'b00, 0, 0, 26'h100, 1, 0, 2'b10, 2'b00, 26'h100));
        vecs.push_back(mk(0, 2'b11, 2'b00, 0, 0, 26'h100, 0, 0, 2'b11, 2'b00, 26'h000));
        vecs.push_back(mk(0, 2'b11, 2'b00, 0, 0, 26'h100, 1, 0, 2'b01, 2'b00, 26'h200));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0, 0, 26'h100, 1, 0, 2'b01, 2'b00, 26'h200));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0, 0, 26'h100, 0, 0, 2'b11, 2'b00, 26'h000));
`endif
        foreach (vecs[i]) run_vec(vecs[i], i);

        // Outstanding limit: fifth strobe stalls until one ack frees a slot.
        do_reset();
        m_cyc_i = 2'b01; m_stb_i = 2'b01; m_we_i = 2'b01;
        m_sel_i[3:0] = 4'hA; m_dat_i[31:0] = 32'hDEADBEEF;
        tick();
        #2;
        check("full_s_we",  64'(s_we_o),  64'h1);
        check("full_s_sel", 64'(s_sel_o), 64'hA);
        check("full_s_dat", 64'(s_dat_o), 64'hDEADBEEF);
        repeat (4) tick();
        #2;
        check("full_stall", 64'(m_stall_o[0]), 64'h1);
        check("full_s_stb", 64'(s_stb_o), 64'h0);
        check("full_out4",  64'(dut.outstanding), 64'h4);
        s_ack_i = 1'b1;
        #1;
        check("full_ack_fwd", 64'(m_ack_o), 64'h1);
        check("full_ack_stb", 64'(s_stb_o), 64'h0);
        tick();
        s_ack_i = 1'b0;
        #2;
        check("freed_s_stb", 64'(s_stb_o), 64'h1);
        check("freed_stall", 64'(m_stall_o[0]), 64'h0);
        tick();
        check("freed_out4", 64'(dut.outstanding), 64'h4);

        // Drain: M0 drops cyc with two outstanding, acks swallowed, then M1 granted.
        do_reset();
        m_cyc_i = 2'b11; m_stb_i = 2'b01;
        tick();
        tick();
        tick();
        m_cyc_i = 2'b10; m_stb_i = 2'b00;
        #2;
        check("drop_s_cyc", 64'(s_cyc_o), 64'h1);
        tick();
        check("drain_out2", 64'(dut.outstanding), 64'h2);
        s_ack_i = 1'b1; s_dat_i = 32'h12345678;
        #2;
        check("drain1_s_cyc",   64'(s_cyc_o),   64'h1);
        check("drain1_s_stb",   64'(s_stb_o),   64'h0);
        check("drain1_m_ack",   64'(m_ack_o),   64'h0);
        check("drain1_m_stall", 64'(m_stall_o), 64'h3);
        check("drain1_m_dat",   64'(m_dat_o),   64'h12345678);
        tick();
        #2;
        check("drain2_m_ack", 64'(m_ack_o), 64'h0);
        check("drain2_s_cyc", 64'(s_cyc_o), 64'h1);
        tick();
        s_ack_i = 1'b0;
        #2;
        check("drain_idle_s_cyc", 64'(s_cyc_o), 64'h0);
        check("drain_idle_m_dat", 64'(m_dat_o), 64'h0);
        tick();
        #2;
        check("m1_grant_stall", 64'(m_stall_o), 64'h1);
        check("m1_grant_s_cyc", 64'(s_cyc_o),   64'h1);

        // Async reset mid-cycle with a request outstanding, then a stray ack.
        m_stb_i = 2'b10;
        tick();
        m_stb_i = 2'b00;
        #2;
        rst_i = 1'b1;
        #1;
        check("arst_s_cyc",   64'(s_cyc_o),   64'h0);
        check("arst_m_stall", 64'(m_stall_o), 64'h3);
        check("arst_out",     64'(dut.outstanding), 64'h0);
        rst_i = 1'b0;
        tick();
        m_cyc_i = 2'b00; s_ack_i = 1'b1;
        #2;
        check("stray_m_ack", 64'(m_ack_o), 64'h0);
        tick();
        s_ack_i = 1'b0;
        check("stray_out", 64'(dut.outstanding), 64'h0);

`ifdef SDRAM_ARB_FIXED_PRIO_EN
        // M1 owns, M0 requests; preemption waits for M1's strobe to drop.
        do_reset();
        m_cyc_i = 2'b10;
        tick();
        m_stb_i = 2'b10;
        #2;
        check("fp_s_stb", 64'(s_stb_o), 64'h1);
        tick();
        m_cyc_i = 2'b11; s_stall_i = 1'b1;
        tick();
        m_stb_i = 2'b00; s_stall_i = 1'b0;
        #2;
        check("fp_hold_s_cyc",   64'(s_cyc_o),   64'h1);
        check("fp_hold_m_stall", 64'(m_stall_o), 64'h1);
        tick();
        s_ack_i = 1'b1;
        #2;
        check("fp_drain_s_cyc", 64'(s_cyc_o), 64'h1);
        check("fp_drain_s_stb", 64'(s_stb_o), 64'h0);
        check("fp_drain_m_ack", 64'(m_ack_o), 64'h0);
        tick();
        s_ack_i = 1'b0;
        #2;
        check("fp_idle_s_cyc", 64'(s_cyc_o), 64'h0);
        tick();
        #2;
        check("fp_m0_stall", 64'(m_stall_o), 64'h2);
        check("fp_m0_s_cyc", 64'(s_cyc_o),   64'h1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
